mem_align_unit: RTL and testbench
=================================

Name: mem_align_unit

Overview:
- Load/store data-path stage between the multicycle control FSM and the physical memory port.
- On a control request it generates word-aligned bus addresses, byte enables and shifted store data.
- It extracts and sign/zero-extends load data.
- Misaligned halfword/word accesses that cross a word boundary are split into two bus transactions.
- It returns a single-cycle completion pulse to control (consumed in the ldr/str states).

Parameters:
- ADDR_W, 32, byte address width; word address = upper ADDR_W-2 bits.

Ports:
- clk  in  1  system clock, all flops rising-edge
- rst  in  1  asynchronous active-high reset
- req_read  in  1  load request from control
- req_write  in  1  store request from control
- req_funct3  in  3  RV32I funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
- req_addr  in  ADDR_W  byte address (rs1+imm)
- req_wdata  in  32  store data (rs2), LSB-justified
- resp  out  1  one-cycle completion pulse to control
- fault  out  1  with resp: request was illegal and no bus access occurred
- rdata  out  32  extended load result; valid with resp, held until next completion
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_address  out  ADDR_W  word-aligned bus address, low 2 bits always 0
- mem_byte_enable  out  4  byte lanes for write (also driven on read)
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  bus read data, valid when mem_resp
- mem_resp  in  1  bus completion, may arrive in the same cycle as the strobe or any later cycle

Behaviour:
- Reset (async, any time including mid-transaction): state IDLE; resp, fault, mem_read, mem_write = 0; mem_address, mem_byte_enable, mem_wdata, rdata = 0. An outstanding bus access is abandoned; the bus must tolerate a dropped strobe.
- States: IDLE, ACC0, ACC1, DONE. All bus outputs are decoded from registered state and latched fields; no combinational path from req_* to mem_*.
- IDLE:
  - Accept when exactly one of req_read/req_write is high; latch funct3, addr, wdata and direction.
  - Go to ACC0, or to DONE with fault=1 if funct3 is illegal for the direction.
  - Both req_read and req_write high is also a fault.
- Sizes and split: size = 1/2/4 bytes; off = addr[1:0]; split = off+size > 4. mask = 0001/0011/1111.
- ACC0:
  - mem_address = {addr[ADDR_W-1:2],00}; be = (mask<<off)[3:0]; wdata0 = (wdata<<8*off)[31:0]; strobe held.
  - On mem_resp, capture mem_rdata as lo. Go to ACC1 if split, else DONE.
  - Strobes deassert in the cycle after mem_resp.
- ACC1:
  - mem_address = word address + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
  - be = mask>>(4-off); wdata1 = wdata>>8*(4-off).
  - On mem_resp, capture hi and go to DONE.
- DONE:
  - resp=1 for exactly one cycle.
  - For loads, rdata = extend(({hi,lo}>>8*off) truncated to size): LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified. Stores leave rdata unchanged.
  - Next state IDLE. Requests are ignored in DONE; the earliest next accept is the cycle after resp.
- Latency (req at cycle 0, memory responding in the strobe cycle): aligned resp at cycle 2; split resp at cycle 3; fault resp at cycle 1. Each extra memory wait cycle adds one.
- Control must drop req_* upon seeing resp; a request still held in IDLE is re-accepted as a new access.

Test Plan:
- Aligned LW at 0x100, mem_rdata=0xDEADBEEF, zero-wait → mem_read cycle 1, be=1111, addr 0x100; resp cycle 2, rdata=0xDEADBEEF.
- LB at 0x103, mem_rdata=0x80FF_FFFF → be=1000; rdata=0xFFFFFF80. LBU at the same address → rdata=0x00000080.
- SH at 0x102, wdata=0x0000ABCD → single write to 0x100, be=1100, mem_wdata=0xABCD0000; resp cycle 2.
- Split SW at 0x0FE, wdata=0x11223344 → write 0x0FC be=1100 data 0x33440000, then write 0x100 be=0011 data 0x00001122; one resp only.
- Split LH at 0xFFFFFFFF, lo=0xAB000000, hi=0x000000CD, 3-cycle mem wait each → addresses 0xFFFFFFFC then 0x00000000; rdata=0xFFFFCDAB; resp at cycle 9.
- Illegal load funct3=011 → no strobe, resp+fault at cycle 1. Separately, assert rst during an ACC1 wait → strobes drop immediately, no resp; next request behaves normally.

Source files
------------

// File: rtl/mem_align_if.sv
// mem_align_if: groups the control-side request/response and the
// physical memory port of the load/store alignment stage.
//   slave  : view of the alignment unit itself
//   master : view of the surrounding control FSM and memory
interface mem_align_if #(
   parameter int ADDR_W = 32
);
   // control request / response
   logic              req_read;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp;
   logic              fault;
   logic [31:0]       rdata;
   // physical memory port
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byte_enable;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_resp;

   modport slave (
      input  req_read, req_write, req_funct3, req_addr, req_wdata,
      input  mem_rdata, mem_resp,
      output resp, fault, rdata,
      output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata
   );

   modport master (
      output req_read, req_write, req_funct3, req_addr, req_wdata,
      output mem_rdata, mem_resp,
      input  resp, fault, rdata,
      input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata
   );
endinterface

// File: rtl/mem_align_unit.sv
// mem_align_unit: load/store alignment stage between the multicycle
// control FSM and the word-wide memory port. Generates word-aligned
// addresses, byte enables and lane-shifted store data, splits accesses
// that straddle a word boundary into two bus transactions, and extracts
// and extends load data. All bus outputs are flops; nothing from req_*
// reaches mem_* without passing through a register.
module mem_align_unit #(
   parameter int ADDR_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   mem_align_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t            state;

   // latched request fields
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              write_q;
   logic [31:0]       lo_q;

   // registered outputs
   logic              resp_q;
   logic              fault_q;
   logic [31:0]       rdata_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic [3:0]        mem_be_q;
   logic [31:0]       mem_wdata_q;

   // lane computation source: live request while idle, latched fields after
   logic [2:0]        cur_f3;
   logic [1:0]        cur_off;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_size;
   logic [3:0]        cur_mask;
   logic [7:0]        be_wide;
   logic [63:0]       wd_wide;
   logic              split;
   logic              req_illegal;
   logic [ADDR_W-3:0] next_word;

   // Extract size bytes starting at byte off of {hi,lo} and extend them.
   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] hi,
                                                input logic [31:0] lo);
      logic [63:0] sh;
      sh = {hi, lo} >> {off, 3'b000};
      case (f3)
         3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_extract = {24'h0, sh[7:0]};
         3'b101:  load_extract = {16'h0, sh[15:0]};
         default: load_extract = sh[31:0];
      endcase
   endfunction

   // Byte lanes and shifted data. The low half of each wide value is the
   // first word's view; the high half is what spills into the next word.
   always_comb begin
      cur_f3    = (state == IDLE) ? bus.req_funct3    : f3_q;
      cur_off   = (state == IDLE) ? bus.req_addr[1:0] : addr_q[1:0];
      cur_wdata = (state == IDLE) ? bus.req_wdata     : wdata_q;
      case (cur_f3[1:0])
         2'b00:   begin cur_size = 4'd1; cur_mask = 4'b0001; end
         2'b01:   begin cur_size = 4'd2; cur_mask = 4'b0011; end
         default: begin cur_size = 4'd4; cur_mask = 4'b1111; end
      endcase
      be_wide   = {4'b0000, cur_mask} << cur_off;
      wd_wide   = {32'h0, cur_wdata} << {cur_off, 3'b000};
      split     = ({2'b00, cur_off} + cur_size) > 4'd4;
      next_word = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
   end

   // Legality of the live request: both strobes at once, or a funct3
   // that has no meaning for the requested direction.
   always_comb begin
      req_illegal = 1'b0;
      if (bus.req_read && bus.req_write)
         req_illegal = 1'b1;
      else if (bus.req_write)
         req_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
      else
         req_illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
   end

   // Control FSM with registered bus and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         f3_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         write_q       <= 1'b0;
         lo_q          <= '0;
         resp_q        <= 1'b0;
         fault_q       <= 1'b0;
         rdata_q       <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_be_q      <= '0;
         mem_wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_q  <= 1'b0;
               fault_q <= 1'b0;
               if (bus.req_read || bus.req_write) begin
                  f3_q    <= bus.req_funct3;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  write_q <= bus.req_write;
                  if (req_illegal) begin
                     state   <= DONE;
                     resp_q  <= 1'b1;
                     fault_q <= 1'b1;
                  end else begin
                     state         <= ACC0;
                     mem_read_q    <= ~bus.req_write;
                     mem_write_q   <= bus.req_write;
                     mem_address_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     mem_be_q      <= be_wide[3:0];
                     mem_wdata_q   <= wd_wide[31:0];
                  end
               end
            end
            ACC0: begin
               if (bus.mem_resp) begin
                  lo_q <= bus.mem_rdata;
                  if (split) begin
                     // strobe stays up; second word of the straddling access
                     state         <= ACC1;
                     mem_address_q <= {next_word, 2'b00};
                     mem_be_q      <= be_wide[7:4];
                     mem_wdata_q   <= wd_wide[63:32];
                  end else begin
                     state       <= DONE;
                     mem_read_q  <= 1'b0;
                     mem_write_q <= 1'b0;
                     resp_q      <= 1'b1;
                     if (!write_q)
                        rdata_q <= load_extract(f3_q, addr_q[1:0], 32'h0, bus.mem_rdata);
                  end
               end
            end
            ACC1: begin
               if (bus.mem_resp) begin
                  state       <= DONE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  resp_q      <= 1'b1;
                  if (!write_q)
                     rdata_q <= load_extract(f3_q, addr_q[1:0], bus.mem_rdata, lo_q);
               end
            end
            default: begin
               // DONE: one-cycle pulse, requests ignored
               resp_q  <= 1'b0;
               fault_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.resp            = resp_q;
   assign bus.fault           = fault_q;
   assign bus.rdata           = rdata_q;
   assign bus.mem_read        = mem_read_q;
   assign bus.mem_write       = mem_write_q;
   assign bus.mem_address     = mem_address_q;
   assign bus.mem_byte_enable = mem_be_q;
   assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: directed vectors against hand-computed values, with a
// small memory responder that logs each bus beat and inserts wait cycles.
module tb_mem_align_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   t0  = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_align_if #(.ADDR_W(32)) bus ();

   mem_align_unit #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // cycle counter, cycle 0 is the cycle the request is presented
   always @(posedge clk) cyc <= cyc + 1;

   // memory responder state
   int          mem_wait = 0;
   int          wcnt     = 0;
   int          n_acc    = 0;
   logic [31:0] rd_q     [4];
   logic [31:0] log_addr [4];
   logic [31:0] log_be   [4];
   logic [31:0] log_wd   [4];
   logic [31:0] log_wr   [4];
   int          log_cyc  [4];

   // responds mem_wait cycles after a strobe appears; logs the beat
   always @(negedge clk) begin
      bus.mem_resp = 1'b0;
      if (rst) begin
         wcnt = 0;
      end else if (bus.mem_read || bus.mem_write) begin
         if (wcnt == mem_wait) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = (n_acc < 4) ? rd_q[n_acc] : 32'h0;
            if (n_acc < 4) begin
               log_addr[n_acc] = bus.mem_address;
               log_be[n_acc]   = {28'h0, bus.mem_byte_enable};
               log_wd[n_acc]   = bus.mem_wdata;
               log_wr[n_acc]   = {31'h0, bus.mem_write};
               log_cyc[n_acc]  = cyc - t0;
            end
            n_acc++;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   int          got_cyc;
   logic [31:0] got_rdata;
   logic        got_fault;

   task automatic drop_req();
      bus.req_read  = 1'b0;
      bus.req_write = 1'b0;
   endtask

   // present one request, wait for resp, confirm it is a single-cycle pulse
   task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk); #1;
      bus.req_read   = rd;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      t0      = cyc;
      n_acc   = 0;
      got_cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cyc - t0 >= 1) drop_req();
         if (bus.resp) begin
            got_cyc   = cyc - t0;
            got_rdata = bus.rdata;
            got_fault = bus.fault;
            break;
         end
      end
      drop_req();
      if (got_cyc < 0) begin
         chk("timeout", {31'h0, bus.resp}, 32'h1);
      end else begin
         @(negedge clk);
         chk("resp_pulse", {31'h0, bus.resp}, 32'h0);
      end
   endtask

   initial begin
      bus.req_read   = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      for (int i = 0; i < 4; i++) rd_q[i] = 32'h0;

      // reset state
      #12;
      chk("rst_resp",  {31'h0, bus.resp},      32'h0);
      chk("rst_fault", {31'h0, bus.fault},     32'h0);
      chk("rst_rd",    {31'h0, bus.mem_read},  32'h0);
      chk("rst_wr",    {31'h0, bus.mem_write}, 32'h0);
      chk("rst_addr",  bus.mem_address,        32'h0);
      chk("rst_be",    {28'h0, bus.mem_byte_enable}, 32'h0);
      chk("rst_wdata", bus.mem_wdata,          32'h0);
      chk("rst_rdata", bus.rdata,              32'h0);
      #10 rst = 1'b0;

      // aligned LW
      mem_wait = 0; rd_q[0] = 32'hDEADBEEF;
      run(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      chk("lw_nacc",  32'(n_acc),   32'd1);
      chk("lw_cyc",   32'(log_cyc[0]), 32'd1);
      chk("lw_addr",  log_addr[0],  32'h100);
      chk("lw_be",    log_be[0],    32'hF);
      chk("lw_dir",   log_wr[0],    32'h0);
      chk("lw_resp",  32'(got_cyc), 32'd2);
      chk("lw_rdata", got_rdata,    32'hDEADBEEF);
      chk("lw_fault", {31'h0, got_fault}, 32'h0);

      // LB / LBU at byte 3
      rd_q[0] = 32'h80FFFFFF;
      run(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
      chk("lb_be",    log_be[0],  32'h8);
      chk("lb_addr",  log_addr[0], 32'h100);
      chk("lb_rdata", got_rdata,  32'hFFFFFF80);
      run(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
      chk("lbu_rdata", got_rdata, 32'h00000080);

      // SH upper half, rdata must be untouched by a store
      run(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD);
      chk("sh_nacc",  32'(n_acc),  32'd1);
      chk("sh_addr",  log_addr[0], 32'h100);
      chk("sh_be",    log_be[0],   32'hC);
      chk("sh_wd",    log_wd[0],   32'hABCD0000);
      chk("sh_dir",   log_wr[0],   32'h1);
      chk("sh_resp",  32'(got_cyc), 32'd2);
      chk("sh_rdata", got_rdata,   32'h00000080);

      // split SW across 0x0FC/0x100
      run(1'b0, 1'b1, 3'b010, 32'h0FE, 32'h11223344);
      chk("sw_nacc",  32'(n_acc),  32'd2);
      chk("sw_addr0", log_addr[0], 32'h0FC);
      chk("sw_be0",   log_be[0],   32'hC);
      chk("sw_wd0",   log_wd[0],   32'h33440000);
      chk("sw_addr1", log_addr[1], 32'h100);
      chk("sw_be1",   log_be[1],   32'h3);
      chk("sw_wd1",   log_wd[1],   32'h00001122);
      chk("sw_resp",  32'(got_cyc), 32'd3);

      // split LH wrapping the address space, 3 wait cycles per beat
      mem_wait = 3; rd_q[0] = 32'hAB000000; rd_q[1] = 32'h000000CD;
      run(1'b1, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
      chk("lh_nacc",  32'(n_acc),     32'd2);
      chk("lh_addr0", log_addr[0],    32'hFFFFFFFC);
      chk("lh_be0",   log_be[0],      32'h8);
      chk("lh_cyc0",  32'(log_cyc[0]), 32'd4);
      chk("lh_addr1", log_addr[1],    32'h00000000);
      chk("lh_be1",   log_be[1],      32'h1);
      chk("lh_cyc1",  32'(log_cyc[1]), 32'd8);
      chk("lh_rdata", got_rdata,      32'hFFFFCDAB);
      chk("lh_resp",  32'(got_cyc),   32'd9);

      // illegal requests: no bus access, fault with resp at cycle 1
      mem_wait = 0;
      run(1'b1, 1'b0, 3'b011, 32'h200, 32'h0);
      chk("ill_ld_nacc",  32'(n_acc),   32'd0);
      chk("ill_ld_fault", {31'h0, got_fault}, 32'h1);
      chk("ill_ld_resp",  32'(got_cyc), 32'd1);
      chk("ill_ld_rdata", got_rdata,    32'hFFFFCDAB);
      run(1'b0, 1'b1, 3'b100, 32'h200, 32'h0);
      chk("ill_st_fault", {31'h0, got_fault}, 32'h1);
      chk("ill_st_nacc",  32'(n_acc),   32'd0);
      run(1'b1, 1'b1, 3'b010, 32'h200, 32'h0);
      chk("both_fault",   {31'h0, got_fault}, 32'h1);
      chk("both_nacc",    32'(n_acc),   32'd0);

      // reset while the second beat of a split load is waiting
      mem_wait = 3; rd_q[0] = 32'hAB000000; rd_q[1] = 32'h000000CD;
      @(posedge clk); #1;
      bus.req_read = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 32'hFFFFFFFF;
      t0 = cyc; n_acc = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 1) drop_req();
      end
      chk("ra_in_acc1", {31'h0, bus.mem_read}, 32'h1);
      chk("ra_addr1",   bus.mem_address,       32'h0);
      #2 rst = 1'b1;
      #1;
      chk("ra_rd",    {31'h0, bus.mem_read},  32'h0);
      chk("ra_wr",    {31'h0, bus.mem_write}, 32'h0);
      chk("ra_be",    {28'h0, bus.mem_byte_enable}, 32'h0);
      chk("ra_rdata", bus.rdata,              32'h0);
      @(posedge clk); #3 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ra_noresp", {31'h0, bus.resp}, 32'h0);
      end

      // normal access after reset
      mem_wait = 0; rd_q[0] = 32'h12345678;
      run(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
      chk("post_addr",  log_addr[0],  32'h200);
      chk("post_resp",  32'(got_cyc), 32'd2);
      chk("post_rdata", got_rdata,    32'h12345678);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
